// File: rtl/udp_tx_framer_pkg.sv
// Shared definitions for the UDP/IPv4 transmit framer and its checksum unit.
// Frame padding is selected in the top level by the UDP_TX_PAD_EN macro.
package udp_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CSUM    = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_FRAME   = 3'd4
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [15:0] IP_VER_IHL_TOS  = 16'h4500;
  localparam logic [15:0] IP_FLAGS_DF     = 16'h4000;
  localparam logic [15:0] IP_TTL_UDP      = 16'h4011;
  localparam logic [9:0]  HDR_WORDS       = 10'd21;
  localparam logic [9:0]  MIN_FRAME_WORDS = 10'd30;

  // Ones-complement add: 17-bit sum with the carry folded back in.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/udp_tx_framer_ip_csum16.sv
// Sequential 16-bit ones-complement accumulator; csum is the complemented sum,
// so an all-ones sum gives 16'h0000. Shared with the receive side.
module ip_csum16
  import udp_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [15:0] acc_r;

  // Accumulator: clear has priority over add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 16'h0000;
    end else if (clr) begin
      acc_r <= 16'h0000;
    end else if (add) begin
      acc_r <= ones_add(acc_r, word);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign csum = ~acc_r;

endmodule

// File: rtl/udp_tx_framer.sv
// UDP/IPv4 transmit framer: checksum, ARP resolve with backoff, 16-bit frame write.
// Define UDP_TX_PAD_EN to zero-pad short frames to 30 words (60 bytes).
module udp_tx_framer
  import udp_tx_framer_pkg::*;
#(
  parameter logic [47:0] SRC_MAC      = 48'h00_14_22_2c_2a_fd,
  parameter logic [15:0] SRC_PORT     = 16'd5000,
  parameter logic [15:0] DEST_PORT    = 16'd5000,
  parameter logic [9:0]  MAX_WORDS    = 10'd736,
  parameter logic [23:0] RETRY_CYCLES = 24'd1_000_000,
  parameter logic [2:0]  MAX_RETRIES  = 3'd3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        send_i,
  input  logic [9:0]  len_i,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dest_ip_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  input  logic [15:0] pl_dat_i,
  input  logic        pl_empty_i,
  output logic        pl_rd_o,
  output logic        arp_cyc_o,
  output logic        arp_stb_o,
  output logic        arp_we_o,
  output logic [31:0] arp_dest_ip_o,
  input  logic        arp_ack_i,
  input  logic        arp_rty_i,
  input  logic [47:0] dest_mac_i,
  output logic        enet_cyc_o,
  output logic        enet_stb_o,
  output logic        enet_we_o,
  output logic [15:0] enet_dat_o,
  input  logic        enet_ack_i,
  input  logic        enet_err_i
);

  state_t      state_r, state_s;
  logic [9:0]  len_r, cnt_r, words_s, last_s;
  logic [31:0] src_ip_r, dest_ip_r;
  logic [47:0] dest_mac_r;
  logic [15:0] ident_r, csum_s, csum_word_s, dat_s, total_len_s, udp_len_s;
  logic [2:0]  retry_r;
  logic [23:0] backoff_r;
  logic        done_r, fail_r, payload_s, stb_s;
  logic        start_s, reject_s, csum_add_s, arp_hit_s, arp_retry_s;
  logic        retry_fail_s, frame_done_s, frame_err_s, word_adv_s;

  assign total_len_s = 16'd28 + {5'd0, len_r, 1'b0};
  assign udp_len_s   = 16'd8 + {5'd0, len_r, 1'b0};
  assign words_s     = HDR_WORDS + len_r;
  assign payload_s   = (state_r == ST_FRAME) && (cnt_r >= HDR_WORDS) && (cnt_r < words_s);
  assign stb_s       = (state_r == ST_FRAME) && !(payload_s && pl_empty_i);

  // Index of the final frame word, including optional minimum-size padding.
  always_comb begin
`ifdef UDP_TX_PAD_EN
    if (words_s < MIN_FRAME_WORDS) begin
      last_s = MIN_FRAME_WORDS - 10'd1;
    end else begin
      last_s = words_s - 10'd1;
    end
`else
    last_s = words_s - 10'd1;
`endif
  end

  ip_csum16 u_csum (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (start_s),
    .add   (csum_add_s),
    .word  (csum_word_s),
    .csum  (csum_s)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and one-cycle control strobes.
  always_comb begin
    state_s      = state_r;
    start_s      = 1'b0;
    reject_s     = 1'b0;
    csum_add_s   = 1'b0;
    arp_hit_s    = 1'b0;
    arp_retry_s  = 1'b0;
    retry_fail_s = 1'b0;
    frame_done_s = 1'b0;
    frame_err_s  = 1'b0;
    word_adv_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (send_i && (len_i > MAX_WORDS)) begin
          reject_s = 1'b1;
        end else if (send_i) begin
          start_s = 1'b1;
          state_s = ST_CSUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CSUM: begin
        csum_add_s = 1'b1;
        if (cnt_r == 10'd8) begin
          state_s = ST_RESOLVE;
        end else begin
          state_s = ST_CSUM;
        end
      end
      ST_RESOLVE: begin
        if (arp_ack_i) begin
          arp_hit_s = 1'b1;
          state_s   = ST_FRAME;
        end else if (arp_rty_i) begin
          arp_retry_s = 1'b1;
          if ((retry_r + 3'd1) == MAX_RETRIES) begin
            retry_fail_s = 1'b1;
            state_s      = ST_IDLE;
          end else begin
            state_s = ST_BACKOFF;
          end
        end else begin
          state_s = ST_RESOLVE;
        end
      end
      ST_BACKOFF: begin
        if (backoff_r == (RETRY_CYCLES - 24'd1)) begin
          state_s = ST_RESOLVE;
        end else begin
          state_s = ST_BACKOFF;
        end
      end
      ST_FRAME: begin
        // An error in the same cycle as an ack discards that word.
        if (enet_err_i) begin
          frame_err_s = 1'b1;
          state_s     = ST_IDLE;
        end else if (enet_ack_i && stb_s) begin
          word_adv_s = 1'b1;
          if (cnt_r == last_s) begin
            frame_done_s = 1'b1;
            state_s      = ST_IDLE;
          end else begin
            state_s = ST_FRAME;
          end
        end else begin
          state_s = ST_FRAME;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Latched request fields, counters, ident and status pulses.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      len_r      <= 10'd0;
      src_ip_r   <= 32'd0;
      dest_ip_r  <= 32'd0;
      dest_mac_r <= 48'd0;
      ident_r    <= 16'd0;
      cnt_r      <= 10'd0;
      retry_r    <= 3'd0;
      backoff_r  <= 24'd0;
      done_r     <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      done_r <= frame_done_s;
      fail_r <= reject_s | retry_fail_s | frame_err_s;
      if (start_s) begin
        len_r     <= len_i;
        src_ip_r  <= src_ip_i;
        dest_ip_r <= dest_ip_i;
        cnt_r     <= 10'd0;
        retry_r   <= 3'd0;
      end else if (csum_add_s) begin
        cnt_r <= (cnt_r == 10'd8) ? 10'd0 : cnt_r + 10'd1;
      end else if (word_adv_s) begin
        cnt_r <= cnt_r + 10'd1;
      end
      if (arp_hit_s) begin
        dest_mac_r <= dest_mac_i;
        retry_r    <= 3'd0;
      end else if (arp_retry_s) begin
        retry_r   <= retry_r + 3'd1;
        backoff_r <= 24'd0;
      end else if (state_r == ST_BACKOFF) begin
        backoff_r <= backoff_r + 24'd1;
      end
      if (frame_done_s) begin
        ident_r <= ident_r + 16'd1;
      end
    end
  end

  // Checksum input word sequence.
  always_comb begin
    csum_word_s = 16'h0000;
    case (cnt_r[3:0])
      4'd0:    csum_word_s = IP_VER_IHL_TOS;
      4'd1:    csum_word_s = total_len_s;
      4'd2:    csum_word_s = ident_r;
      4'd3:    csum_word_s = IP_FLAGS_DF;
      4'd4:    csum_word_s = IP_TTL_UDP;
      4'd5:    csum_word_s = src_ip_r[31:16];
      4'd6:    csum_word_s = src_ip_r[15:0];
      4'd7:    csum_word_s = dest_ip_r[31:16];
      4'd8:    csum_word_s = dest_ip_r[15:0];
      default: csum_word_s = 16'h0000;
    endcase
  end

  // Frame word map; beyond the headers it is payload, then zero padding.
  always_comb begin
    dat_s = 16'h0000;
    if (state_r == ST_FRAME) begin
      case (cnt_r)
        10'd0:   dat_s = dest_mac_r[47:32];
        10'd1:   dat_s = dest_mac_r[31:16];
        10'd2:   dat_s = dest_mac_r[15:0];
        10'd3:   dat_s = SRC_MAC[47:32];
        10'd4:   dat_s = SRC_MAC[31:16];
        10'd5:   dat_s = SRC_MAC[15:0];
        10'd6:   dat_s = ETHERTYPE_IPV4;
        10'd7:   dat_s = IP_VER_IHL_TOS;
        10'd8:   dat_s = total_len_s;
        10'd9:   dat_s = ident_r;
        10'd10:  dat_s = IP_FLAGS_DF;
        10'd11:  dat_s = IP_TTL_UDP;
        10'd12:  dat_s = csum_s;
        10'd13:  dat_s = src_ip_r[31:16];
        10'd14:  dat_s = src_ip_r[15:0];
        10'd15:  dat_s = dest_ip_r[31:16];
        10'd16:  dat_s = dest_ip_r[15:0];
        10'd17:  dat_s = SRC_PORT;
        10'd18:  dat_s = DEST_PORT;
        10'd19:  dat_s = udp_len_s;
        10'd20:  dat_s = 16'h0000;
        default: dat_s = payload_s ? pl_dat_i : 16'h0000;
      endcase
    end else begin
      dat_s = 16'h0000;
    end
  end

  assign busy_o        = (state_r != ST_IDLE);
  assign done_o        = done_r;
  assign fail_o        = fail_r;
  assign pl_rd_o       = enet_ack_i & payload_s;
  assign arp_cyc_o     = (state_r == ST_RESOLVE);
  assign arp_stb_o     = (state_r == ST_RESOLVE);
  assign arp_we_o      = (state_r == ST_RESOLVE);
  assign arp_dest_ip_o = dest_ip_r;
  assign enet_cyc_o    = (state_r == ST_FRAME);
  assign enet_stb_o    = stb_s;
  assign enet_we_o     = (state_r == ST_FRAME);
  assign enet_dat_o    = dat_s;

endmodule
